buzzer_arbiter: RTL

- Shares the single buzzer, octave and LED output path among three requesters: 0 = free-play keyboard, 1 = auto-play song engine, 2 = learn/prompt mode.
- Grants one owner at a time and forwards that owner's note, octave and LED bits.
- Inserts a silent gap on every ownership change to prevent clicks.
- Enforces a minimum hold time before preemption; sits between the mode blocks and the buzzer driver.

---
 rtl/buzzer_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: shares one buzzer/octave/LED path among three sources
// (0 = keyboard, 1 = song engine, 2 = learn mode). Every ownership change
// passes through a silent gap; the default build uses fixed priority 0 > 2 > 1
// with a minimum hold before preemption. Defining BUZZER_ARB_ROUND_ROBIN_EN
// switches to round-robin granting with no preemption.
module buzzer_arbiter #(
  parameter int GAP_CYCLES = 100000,
  parameter int MIN_HOLD   = 1000000,
  parameter int N_SRC      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req_i,
  input  logic [3:0]       note0_i,
  input  logic [3:0]       note1_i,
  input  logic [3:0]       note2_i,
  input  logic [1:0]       oct0_i,
  input  logic [1:0]       oct1_i,
  input  logic [1:0]       oct2_i,
  input  logic [6:0]       led0_i,
  input  logic [6:0]       led1_i,
  input  logic [6:0]       led2_i,
  output logic [3:0]       note_o,
  output logic [1:0]       octave_o,
  output logic [6:0]       led_o,
  output logic [N_SRC-1:0] grant_o,
  output logic             busy_o,
  output logic             switch_o,
  output logic             end_o
);
  localparam int GAP_MAX  = (GAP_CYCLES > 1) ? GAP_CYCLES : 1;
  localparam int HOLD_SAT = (MIN_HOLD > 1) ? MIN_HOLD : 1;
  localparam int GW       = $clog2(GAP_MAX + 1);
  localparam int HW       = $clog2(HOLD_SAT + 1);
  // GAP_MAX equals GAP_CYCLES whenever a gap exists, so this is GAP_CYCLES-1
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_MAX - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_OWN} state_t;

  state_t      r_state, w_state_nx;
  logic [1:0]  r_sel, w_sel_nx;     // pending winner in GAP, owner in OWN
  logic [GW-1:0] r_gap, w_gap_nx;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic        r_fprev;             // owner showed 4'hF last cycle
  logic [1:0]  w_win;
  logic        w_any, w_sel_req, w_start;
  logic [3:0]  w_note_src;
  logic [1:0]  w_oct_src;
  logic [6:0]  w_led_src;
  logic        w_own_nx, w_is_f, w_switch;

  assign w_any = |req_i;

`ifdef BUZZER_ARB_ROUND_ROBIN_EN
  logic [1:0] r_ptr;
  logic [1:0] w_rr_idx;

  // Round-robin: first requester at or above the pointer, wrapping
  always_comb begin
    w_win    = 2'd0;
    w_rr_idx = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      w_rr_idx = 2'((int'(r_ptr) + k) % 3);
      if (req_i[w_rr_idx]) w_win = w_rr_idx;
    end
  end

  // Pointer moves one past each source as it is granted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_ptr <= 2'd0;
    else if (w_switch) r_ptr <= (w_sel_nx == 2'd2) ? 2'd0 : w_sel_nx + 2'd1;
  end
`else
  logic w_hp;

  function automatic logic [1:0] f_rank(input logic [1:0] s);
    case (s)
      2'd0:    f_rank = 2'd0;
      2'd2:    f_rank = 2'd1;
      default: f_rank = 2'd2;
    endcase
  endfunction

  // Fixed priority 0 > 2 > 1; w_hp flags a requester above the current selection
  always_comb begin
    w_win = req_i[0] ? 2'd0 : (req_i[2] ? 2'd2 : 2'd1);
    w_hp  = w_any && (f_rank(w_win) < f_rank(r_sel));
  end
`endif

  // Request line of the selected source
  always_comb begin
    case (r_sel)
      2'd0:    w_sel_req = req_i[0];
      2'd1:    w_sel_req = req_i[1];
      2'd2:    w_sel_req = req_i[2];
      default: w_sel_req = 1'b0;
    endcase
  end

  // State, selection and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_gap   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
      r_gap   <= w_gap_nx;
      r_hold  <= w_hold_nx;
    end
  end

  // Next-state: w_start means "hand the buzzer to w_win via a fresh gap"
  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_gap_nx   = r_gap;
    w_hold_nx  = r_hold;
    w_start    = 1'b0;
    unique case (r_state)
      S_IDLE: w_start = w_any;
      S_GAP: begin
        if (!w_sel_req) begin
          if (w_any) w_start = 1'b1;
          else       w_state_nx = S_IDLE;
        end else begin
`ifndef BUZZER_ARB_ROUND_ROBIN_EN
          // better candidate takes the slot but the gap keeps counting
          if (w_hp) w_sel_nx = w_win;
`endif
          if (r_gap == '0) w_state_nx = S_OWN;
          else             w_gap_nx   = r_gap - 1'b1;
        end
      end
      S_OWN: begin
        if (!w_sel_req) begin
          if (w_any) w_start = 1'b1;
          else       w_state_nx = S_IDLE;
        end
`ifndef BUZZER_ARB_ROUND_ROBIN_EN
        else if (w_hp && (r_hold == HOLD_MAX)) w_start = 1'b1;
`endif
        else if (r_hold != HOLD_MAX) w_hold_nx = r_hold + 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_start) begin
      w_sel_nx = w_win;
      if (GAP_CYCLES == 0) w_state_nx = S_OWN;
      else begin
        w_state_nx = S_GAP;
        w_gap_nx   = GAP_LOAD;
      end
    end
    // hold restarts from zero on every new grant
    if ((w_state_nx != S_OWN) || (r_state != S_OWN) || w_start) w_hold_nx = '0;
  end

  // Output values for the next cycle, taken from the next owner's inputs
  always_comb begin
    w_note_src = 4'h0;
    w_oct_src  = 2'd0;
    w_led_src  = 7'h00;
    case (w_sel_nx)
      2'd0:    begin w_note_src = note0_i; w_oct_src = oct0_i; w_led_src = led0_i; end
      2'd1:    begin w_note_src = note1_i; w_oct_src = oct1_i; w_led_src = led1_i; end
      2'd2:    begin w_note_src = note2_i; w_oct_src = oct2_i; w_led_src = led2_i; end
      default: ;
    endcase
    w_own_nx = (w_state_nx == S_OWN);
    w_is_f   = w_own_nx && (w_note_src == 4'hF);
    w_switch = w_own_nx && ((r_state != S_OWN) || (w_sel_nx != r_sel));
  end

  // Registered outputs; the end marker is replaced by a rest
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_o   <= 4'h0;
      octave_o <= 2'd0;
      led_o    <= 7'h00;
      grant_o  <= '0;
      busy_o   <= 1'b0;
      switch_o <= 1'b0;
      end_o    <= 1'b0;
      r_fprev  <= 1'b0;
    end else begin
      note_o   <= (w_own_nx && !w_is_f) ? w_note_src : 4'h0;
      octave_o <= w_own_nx ? w_oct_src : 2'd0;
      led_o    <= w_own_nx ? w_led_src : 7'h00;
      grant_o  <= w_own_nx ? (N_SRC'(1) << w_sel_nx) : '0;
      busy_o   <= (w_state_nx != S_IDLE);
      switch_o <= w_switch;
      end_o    <= w_is_f && (!r_fprev || w_switch);
      r_fprev  <= w_is_f;
    end
  end
endmodule
